// File: rtl/uart_rx_cfg.sv
// Purpose: configurable UART receiver (5..9 data bits, none/even/odd parity, 1..2 stop bits) with synchroniser and false-start rejection.
// Latency: strobe H+(W+P+STOP_BITS)*CPB+1 cycles after the first synchronised low start cycle (+2 cycles from the pin).
// Backpressure: none; the word and flags hold until the next frame completes and must be taken on the strobe.
module uart_rx_cfg #(
  parameter int CLOCK_PER_BIT = 434,
  parameter int DATAWIDTH_BUS = 8,
  parameter int PARITY_MODE   = 0,
  parameter int STOP_BITS     = 1,
  parameter int STATE_SIZE    = 3
) (
  input  logic                     UART_RX_CFG_CLOCK_50,
  input  logic                     UART_RX_CFG_RESET_InLow,
  input  logic                     UART_RX_CFG_rx_InLow,
  output logic                     UART_RX_CFG_newData_Out,
  output logic [DATAWIDTH_BUS-1:0] UART_RX_CFG_data_Out,
  output logic                     UART_RX_CFG_parityError_Out,
  output logic                     UART_RX_CFG_frameError_Out,
  output logic                     UART_RX_CFG_busy_Out
);

  localparam int HALF  = CLOCK_PER_BIT / 2;
  localparam int CNT_W = $clog2(CLOCK_PER_BIT);
  localparam int IDX_W = $clog2(DATAWIDTH_BUS);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLOCK_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATAWIDTH_BUS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [STATE_SIZE-1:0] {
    IDLE    = STATE_SIZE'(0),
    START   = STATE_SIZE'(1),
    DATA    = STATE_SIZE'(2),
    PARITY  = STATE_SIZE'(3),
    STOP    = STATE_SIZE'(4),
    CLEANUP = STATE_SIZE'(5)
  } state_t;

  state_t                   state;
  logic                     rxMeta, rxSync, rxPrev;
  logic [CNT_W-1:0]         bitCount;
  logic [IDX_W-1:0]         bitIndex;
  logic                     stopIndex;
  logic [DATAWIDTH_BUS-1:0] shiftData;
  logic                     pendParity, pendFrame;
  logic                     newData, parityError, frameError, busy;
  logic [DATAWIDTH_BUS-1:0] dataReg;

  logic startEdge, stopErr, parityXor, parityErrNow;

  // Start is a falling edge of the synchronised line, so a held-low line (break) never retriggers.
  assign startEdge    = rxPrev & ~rxSync;
  // Framing error accumulates over all stop bits of the frame.
  assign stopErr      = pendFrame | ~rxSync;
  assign parityXor    = (^shiftData) ^ rxSync;
  assign parityErrNow = (PARITY_MODE == 2) ? ~parityXor : parityXor;

  // Two-flop synchroniser plus one delayed copy for edge detection; all idle-high out of reset.
  always_ff @(posedge UART_RX_CFG_CLOCK_50 or negedge UART_RX_CFG_RESET_InLow) begin
    if (!UART_RX_CFG_RESET_InLow) begin
      rxMeta <= 1'b1;
      rxSync <= 1'b1;
      rxPrev <= 1'b1;
    end else begin
      rxMeta <= UART_RX_CFG_rx_InLow;
      rxSync <= rxMeta;
      rxPrev <= rxSync;
    end
  end

  // Frame FSM: mid-bit sampling, shift LSB first, registered strobe/word/flags loaded on the final stop sample.
  always_ff @(posedge UART_RX_CFG_CLOCK_50 or negedge UART_RX_CFG_RESET_InLow) begin
    if (!UART_RX_CFG_RESET_InLow) begin
      state       <= IDLE;
      bitCount    <= '0;
      bitIndex    <= '0;
      stopIndex   <= 1'b0;
      shiftData   <= '0;
      pendParity  <= 1'b0;
      pendFrame   <= 1'b0;
      newData     <= 1'b0;
      dataReg     <= '0;
      parityError <= 1'b0;
      frameError  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      newData <= 1'b0;
      case (state)
        IDLE: begin
          if (startEdge) begin
            state    <= START;
            bitCount <= '0;
            busy     <= 1'b1;
          end
        end
        START: begin
          if (bitCount == HALF_LAST) begin
            bitCount <= '0;
            if (rxSync) begin
              // Line back high at mid start bit: glitch, drop it silently.
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state      <= DATA;
              bitIndex   <= '0;
              pendParity <= 1'b0;
              pendFrame  <= 1'b0;
            end
          end else begin
            bitCount <= bitCount + CNT_W'(1);
          end
        end
        DATA: begin
          if (bitCount == BIT_LAST) begin
            bitCount  <= '0;
            shiftData <= {rxSync, shiftData[DATAWIDTH_BUS-1:1]};
            if (bitIndex == IDX_LAST) begin
              state     <= (PARITY_MODE != 0) ? PARITY : STOP;
              stopIndex <= 1'b0;
            end else begin
              bitIndex <= bitIndex + IDX_W'(1);
            end
          end else begin
            bitCount <= bitCount + CNT_W'(1);
          end
        end
        PARITY: begin
          if (bitCount == BIT_LAST) begin
            bitCount   <= '0;
            pendParity <= parityErrNow;
            state      <= STOP;
            stopIndex  <= 1'b0;
          end else begin
            bitCount <= bitCount + CNT_W'(1);
          end
        end
        STOP: begin
          if (bitCount == BIT_LAST) begin
            bitCount <= '0;
            if (stopIndex == STOP_LAST) begin
              state       <= CLEANUP;
              newData     <= 1'b1;
              dataReg     <= shiftData;
              parityError <= pendParity;
              frameError  <= stopErr;
            end else begin
              pendFrame <= stopErr;
              stopIndex <= 1'b1;
            end
          end else begin
            bitCount <= bitCount + CNT_W'(1);
          end
        end
        CLEANUP: begin
          // A start edge landing here belongs to a back-to-back frame; take it now.
          if (startEdge) begin
            state    <= START;
            bitCount <= '0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign UART_RX_CFG_newData_Out     = newData;
  assign UART_RX_CFG_data_Out        = dataReg;
  assign UART_RX_CFG_parityError_Out = parityError;
  assign UART_RX_CFG_frameError_Out  = frameError;
  assign UART_RX_CFG_busy_Out        = busy;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: four instances at CPB=16 (8N1, 8E1, 8O1, 9O2) driven by serial frames.
// Expected words are queued as frames are driven and matched against strobes captured on the falling edge.
// Line stimulus is fire-and-forget; no backpressure exists on the receiver.
module tb_uart_rx_cfg;

  localparam int CPB = 16;

  logic       clk  = 1'b0;
  logic       rstN = 1'b0;
  logic [3:0] rx   = 4'hF;
  logic [3:0] nd, pe, fe, bz;
  logic [7:0] d0, d1, d2;
  logic [8:0] d3;
  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;

  typedef struct {
    int         inst;
    logic [8:0] data;
    logic       pe;
    logic       fe;
    int         cyc;
  } rec_t;

  rec_t expQ[$];
  rec_t obsQ[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_cfg #(.CLOCK_PER_BIT(CPB), .DATAWIDTH_BUS(8), .PARITY_MODE(0), .STOP_BITS(1), .STATE_SIZE(3)) u0 (
    .UART_RX_CFG_CLOCK_50(clk), .UART_RX_CFG_RESET_InLow(rstN), .UART_RX_CFG_rx_InLow(rx[0]),
    .UART_RX_CFG_newData_Out(nd[0]), .UART_RX_CFG_data_Out(d0), .UART_RX_CFG_parityError_Out(pe[0]),
    .UART_RX_CFG_frameError_Out(fe[0]), .UART_RX_CFG_busy_Out(bz[0]));

  uart_rx_cfg #(.CLOCK_PER_BIT(CPB), .DATAWIDTH_BUS(8), .PARITY_MODE(1), .STOP_BITS(1), .STATE_SIZE(3)) u1 (
    .UART_RX_CFG_CLOCK_50(clk), .UART_RX_CFG_RESET_InLow(rstN), .UART_RX_CFG_rx_InLow(rx[1]),
    .UART_RX_CFG_newData_Out(nd[1]), .UART_RX_CFG_data_Out(d1), .UART_RX_CFG_parityError_Out(pe[1]),
    .UART_RX_CFG_frameError_Out(fe[1]), .UART_RX_CFG_busy_Out(bz[1]));

  uart_rx_cfg #(.CLOCK_PER_BIT(CPB), .DATAWIDTH_BUS(8), .PARITY_MODE(2), .STOP_BITS(1), .STATE_SIZE(3)) u2 (
    .UART_RX_CFG_CLOCK_50(clk), .UART_RX_CFG_RESET_InLow(rstN), .UART_RX_CFG_rx_InLow(rx[2]),
    .UART_RX_CFG_newData_Out(nd[2]), .UART_RX_CFG_data_Out(d2), .UART_RX_CFG_parityError_Out(pe[2]),
    .UART_RX_CFG_frameError_Out(fe[2]), .UART_RX_CFG_busy_Out(bz[2]));

  uart_rx_cfg #(.CLOCK_PER_BIT(CPB), .DATAWIDTH_BUS(9), .PARITY_MODE(2), .STOP_BITS(2), .STATE_SIZE(3)) u3 (
    .UART_RX_CFG_CLOCK_50(clk), .UART_RX_CFG_RESET_InLow(rstN), .UART_RX_CFG_rx_InLow(rx[3]),
    .UART_RX_CFG_newData_Out(nd[3]), .UART_RX_CFG_data_Out(d3), .UART_RX_CFG_parityError_Out(pe[3]),
    .UART_RX_CFG_frameError_Out(fe[3]), .UART_RX_CFG_busy_Out(bz[3]));

  function automatic logic [8:0] dataOf(input int i);
    case (i)
      0:       dataOf = {1'b0, d0};
      1:       dataOf = {1'b0, d1};
      2:       dataOf = {1'b0, d2};
      default: dataOf = d3;
    endcase
  endfunction

  // Capture every strobe away from the rising edge.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (nd[i] === 1'b1)
        obsQ.push_back('{inst: i, data: dataOf(i), pe: pe[i], fe: fe[i], cyc: cyc});
    end
  end

  // Drive one frame on line i; each bit lasts CPB cycles, the line is left at the stop value.
  task automatic sendFrame(input int i, input logic [8:0] data, input int w, input bit hasPar,
                           input logic pbit, input int stops, input logic stopVal);
    rx[i] = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    for (int k = 0; k < w; k++) begin
      rx[i] = data[k];
      repeat (CPB) @(posedge clk);
      #1;
    end
    if (hasPar) begin
      rx[i] = pbit;
      repeat (CPB) @(posedge clk);
      #1;
    end
    for (int s = 0; s < stops; s++) begin
      rx[i] = stopVal;
      repeat (CPB) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rstN = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({nd, pe, fe, bz} !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_flags: got nd/pe/fe/bz %h, want 0000", {nd, pe, fe, bz});
    end
    vectors++;
    if ({d3, d2, d1, d0} !== 33'h0) begin
      miscompares++;
      $display("FAIL reset_data: got %h %h %h %h, want all zero", d3, d2, d1, d0);
    end
    rstN = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    vectors++;
    if (bz !== 4'h0 || obsQ.size() != 0) begin
      miscompares++;
      $display("FAIL reset_release_idle: got busy %b strobes %0d, want 0000 and 0", bz, obsQ.size());
    end
  endtask

  task automatic test_basic;
    rec_t e, o;
    @(posedge clk);
    #1;
    expQ.push_back('{inst: 0, data: 9'h0A5, pe: 1'b0, fe: 1'b0, cyc: 0});
    fork
      sendFrame(0, 9'h0A5, 8, 1'b0, 1'b0, 1, 1'b1);
      begin
        // Pin falls now; cycle t opens 2 edges later, so cycle t+153 opens 155 edges later.
        repeat (155) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (nd[0] !== 1'b1 || bz[0] !== 1'b1) begin
          miscompares++;
          $display("FAIL basic_strobe_time: got nd %b busy %b at t+153, want 1 1", nd[0], bz[0]);
        end
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (nd[0] !== 1'b0 || bz[0] !== 1'b0) begin
          miscompares++;
          $display("FAIL basic_after_strobe: got nd %b busy %b at t+154, want 0 0", nd[0], bz[0]);
        end
      end
    join
    for (int k = 0; k < 200 && obsQ.size() < expQ.size(); k++) @(posedge clk);
    vectors++;
    if (obsQ.size() != expQ.size()) begin
      miscompares++;
      $display("FAIL basic_count: got %0d strobes, want %0d", obsQ.size(), expQ.size());
    end
    while (expQ.size() > 0 && obsQ.size() > 0) begin
      e = expQ.pop_front();
      o = obsQ.pop_front();
      vectors++;
      if (o.inst !== e.inst || o.data !== e.data || o.pe !== e.pe || o.fe !== e.fe) begin
        miscompares++;
        $display("FAIL basic_word: got u%0d %h pe %b fe %b, want u%0d %h pe %b fe %b",
                 o.inst, o.data, o.pe, o.fe, e.inst, e.data, e.pe, e.fe);
      end
    end
    expQ.delete();
    obsQ.delete();
  endtask

  task automatic test_parity;
    rec_t e, o;
    logic [8:0] b;
    int ones;
    logic err;
    @(posedge clk);
    #1;
    b = 9'h007;
    ones = $countones(b);
    // Instance 1 is even parity, instance 2 odd; each gets parity bit 1 then 0.
    for (int m = 1; m <= 2; m++) begin
      for (int p = 1; p >= 0; p--) begin
        err = (m == 1) ? (((ones + p) % 2) == 1) : (((ones + p) % 2) == 0);
        expQ.push_back('{inst: m, data: b, pe: err, fe: 1'b0, cyc: 0});
        sendFrame(m, b, 8, 1'b1, 1'(p), 1, 1'b1);
      end
    end
    for (int k = 0; k < 200 && obsQ.size() < expQ.size(); k++) @(posedge clk);
    vectors++;
    if (obsQ.size() != expQ.size()) begin
      miscompares++;
      $display("FAIL parity_count: got %0d strobes, want %0d", obsQ.size(), expQ.size());
    end
    while (expQ.size() > 0 && obsQ.size() > 0) begin
      e = expQ.pop_front();
      o = obsQ.pop_front();
      vectors++;
      if (o.inst !== e.inst || o.data !== e.data || o.pe !== e.pe || o.fe !== e.fe) begin
        miscompares++;
        $display("FAIL parity_word: got u%0d %h pe %b fe %b, want u%0d %h pe %b fe %b",
                 o.inst, o.data, o.pe, o.fe, e.inst, e.data, e.pe, e.fe);
      end
    end
    expQ.delete();
    obsQ.delete();
  endtask

  task automatic test_framing;
    rec_t e, o;
    @(posedge clk);
    #1;
    expQ.push_back('{inst: 0, data: 9'h03C, pe: 1'b0, fe: 1'b1, cyc: 0});
    sendFrame(0, 9'h03C, 8, 1'b0, 1'b0, 1, 1'b0);
    // Break: line stays low for 40 bit times.
    repeat (40 * CPB) @(posedge clk);
    #1;
    rx[0] = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    #1;
    vectors++;
    if (obsQ.size() != 1 || d0 !== 8'h3C || fe[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL framing_break: got %0d strobes data %h fe %b, want 1 3c 1", obsQ.size(), d0, fe[0]);
    end
    expQ.push_back('{inst: 0, data: 9'h055, pe: 1'b0, fe: 1'b0, cyc: 0});
    sendFrame(0, 9'h055, 8, 1'b0, 1'b0, 1, 1'b1);
    for (int k = 0; k < 200 && obsQ.size() < expQ.size(); k++) @(posedge clk);
    vectors++;
    if (obsQ.size() != expQ.size()) begin
      miscompares++;
      $display("FAIL framing_count: got %0d strobes, want %0d", obsQ.size(), expQ.size());
    end
    while (expQ.size() > 0 && obsQ.size() > 0) begin
      e = expQ.pop_front();
      o = obsQ.pop_front();
      vectors++;
      if (o.inst !== e.inst || o.data !== e.data || o.pe !== e.pe || o.fe !== e.fe) begin
        miscompares++;
        $display("FAIL framing_word: got u%0d %h pe %b fe %b, want u%0d %h pe %b fe %b",
                 o.inst, o.data, o.pe, o.fe, e.inst, e.data, e.pe, e.fe);
      end
    end
    expQ.delete();
    obsQ.delete();
  endtask

  task automatic test_false_start;
    rec_t e, o;
    @(posedge clk);
    #1;
    rx[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rx[0] = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    #1;
    vectors++;
    if (obsQ.size() != 0 || bz[0] !== 1'b0 || d0 !== 8'h55 || fe[0] !== 1'b0 || pe[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL false_start_reject: got %0d strobes busy %b data %h fe %b pe %b, want 0 0 55 0 0",
               obsQ.size(), bz[0], d0, fe[0], pe[0]);
    end
    expQ.push_back('{inst: 0, data: 9'h081, pe: 1'b0, fe: 1'b0, cyc: 0});
    sendFrame(0, 9'h081, 8, 1'b0, 1'b0, 1, 1'b1);
    for (int k = 0; k < 200 && obsQ.size() < expQ.size(); k++) @(posedge clk);
    vectors++;
    if (obsQ.size() != expQ.size()) begin
      miscompares++;
      $display("FAIL false_start_count: got %0d strobes, want %0d", obsQ.size(), expQ.size());
    end
    while (expQ.size() > 0 && obsQ.size() > 0) begin
      e = expQ.pop_front();
      o = obsQ.pop_front();
      vectors++;
      if (o.inst !== e.inst || o.data !== e.data || o.pe !== e.pe || o.fe !== e.fe) begin
        miscompares++;
        $display("FAIL false_start_word: got u%0d %h pe %b fe %b, want u%0d %h pe %b fe %b",
                 o.inst, o.data, o.pe, o.fe, e.inst, e.data, e.pe, e.fe);
      end
    end
    expQ.delete();
    obsQ.delete();
  endtask

  task automatic test_reset_mid_frame;
    rec_t e, o;
    @(posedge clk);
    #1;
    fork
      sendFrame(0, 9'h0FF, 8, 1'b0, 1'b0, 1, 1'b1);
      begin
        // Middle of data bit 4: start bit plus four data bits plus half a bit.
        repeat (5 * CPB + CPB / 2) @(posedge clk);
        #2;
        vectors++;
        if (bz[0] !== 1'b1) begin
          miscompares++;
          $display("FAIL reset_mid_busy: got busy %b before reset, want 1", bz[0]);
        end
        rstN = 1'b0;
        #1;
        vectors++;
        if (nd[0] !== 1'b0 || d0 !== 8'h00 || pe[0] !== 1'b0 || fe[0] !== 1'b0 || bz[0] !== 1'b0) begin
          miscompares++;
          $display("FAIL reset_mid_outputs: got nd %b data %h pe %b fe %b busy %b, want 0 00 0 0 0",
                   nd[0], d0, pe[0], fe[0], bz[0]);
        end
        repeat (2) @(posedge clk);
        #2;
        rstN = 1'b1;
      end
    join
    repeat (2 * CPB) @(posedge clk);
    #1;
    vectors++;
    if (obsQ.size() != 0) begin
      miscompares++;
      $display("FAIL reset_mid_spurious: got %0d strobes, want 0", obsQ.size());
    end
    expQ.push_back('{inst: 0, data: 9'h012, pe: 1'b0, fe: 1'b0, cyc: 0});
    sendFrame(0, 9'h012, 8, 1'b0, 1'b0, 1, 1'b1);
    for (int k = 0; k < 200 && obsQ.size() < expQ.size(); k++) @(posedge clk);
    vectors++;
    if (obsQ.size() != expQ.size()) begin
      miscompares++;
      $display("FAIL reset_mid_count: got %0d strobes, want %0d", obsQ.size(), expQ.size());
    end
    while (expQ.size() > 0 && obsQ.size() > 0) begin
      e = expQ.pop_front();
      o = obsQ.pop_front();
      vectors++;
      if (o.inst !== e.inst || o.data !== e.data || o.pe !== e.pe || o.fe !== e.fe) begin
        miscompares++;
        $display("FAIL reset_mid_word: got u%0d %h pe %b fe %b, want u%0d %h pe %b fe %b",
                 o.inst, o.data, o.pe, o.fe, e.inst, e.data, e.pe, e.fe);
      end
    end
    expQ.delete();
    obsQ.delete();
  endtask

  task automatic test_back_to_back;
    rec_t e, o;
    logic [8:0] fr [2];
    int firstCyc;
    logic pb;
    @(posedge clk);
    #1;
    fr[0] = 9'h1AB;
    fr[1] = 9'h054;
    firstCyc = -1;
    for (int f = 0; f < 2; f++) begin
      // Odd parity: the parity bit makes the count of ones odd.
      pb = ($countones(fr[f]) % 2 == 0) ? 1'b1 : 1'b0;
      expQ.push_back('{inst: 3, data: fr[f], pe: 1'b0, fe: 1'b0, cyc: 0});
      sendFrame(3, fr[f], 9, 1'b1, pb, 2, 1'b1);
    end
    for (int k = 0; k < 200 && obsQ.size() < expQ.size(); k++) @(posedge clk);
    vectors++;
    if (obsQ.size() != expQ.size()) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d strobes, want %0d", obsQ.size(), expQ.size());
    end
    while (expQ.size() > 0 && obsQ.size() > 0) begin
      e = expQ.pop_front();
      o = obsQ.pop_front();
      vectors++;
      if (o.inst !== e.inst || o.data !== e.data || o.pe !== e.pe || o.fe !== e.fe) begin
        miscompares++;
        $display("FAIL b2b_word: got u%0d %h pe %b fe %b, want u%0d %h pe %b fe %b",
                 o.inst, o.data, o.pe, o.fe, e.inst, e.data, e.pe, e.fe);
      end
      if (firstCyc < 0) begin
        firstCyc = o.cyc;
      end else begin
        vectors++;
        if (o.cyc - firstCyc != (1 + 9 + 1 + 2) * CPB) begin
          miscompares++;
          $display("FAIL b2b_spacing: got %0d cycles between strobes, want %0d",
                   o.cyc - firstCyc, (1 + 9 + 1 + 2) * CPB);
        end
      end
    end
    expQ.delete();
    obsQ.delete();
  endtask

  initial begin
    repeat (30000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded 30000 cycles, want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_framing();
    test_false_start();
    test_reset_mid_frame();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised UART receiver and successor to the fixed 8N1 receive block. It adds a compile-time data width of 5–9 bits, optional even/odd parity, and one or two stop bits. It also adds an input synchroniser, false-start rejection, and per-frame parity and framing error flags. The block sits between the board RX pin and the byte-consuming logic, and presents each received word with a one-cycle strobe.

## Interface
Parameters:
- CLOCK_PER_BIT, 434 — clock cycles per bit (50 MHz / 115200); minimum 4.
- DATAWIDTH_BUS, 8 — data bits per frame, 5..9.
- PARITY_MODE, 0 — 0 none, 1 even, 2 odd.
- STOP_BITS, 1 — 1 or 2.
- STATE_SIZE, 3 — state register width.

Ports:
- UART_RX_CFG_CLOCK_50  in  1 — system clock; all logic on the rising edge.
- UART_RX_CFG_RESET_InLow  in  1 — reset, asynchronous, active-low.
- UART_RX_CFG_rx_InLow  in  1 — serial line, idle high, asynchronous to the clock.
- UART_RX_CFG_newData_Out  out  1 — one-cycle strobe when a frame completes.
- UART_RX_CFG_data_Out  out  DATAWIDTH_BUS — last received word, LSB = first data bit.
- UART_RX_CFG_parityError_Out  out  1 — parity mismatch on the last frame; always 0 when PARITY_MODE = 0.
- UART_RX_CFG_frameError_Out  out  1 — a stop bit was sampled low on the last frame.
- UART_RX_CFG_busy_Out  out  1 — a frame is in progress.

## Operation
- **Input synchroniser.** The rx input passes through 2 flip-flops, both reset to 1. All sampling uses the synchronised line S.
- **Bit timing.** H = CLOCK_PER_BIT/2 (integer). The bit counter is wide enough for CLOCK_PER_BIT-1.
- **IDLE.** Wait for a falling edge on S: previous S = 1 and current S = 0. Then clear the counter and go to START.
- **START.** At count H-1, sample S.
  - S = 1: false start. Return to IDLE with no strobe and no flag change.
  - S = 0: go to DATA.
- **DATA.** Sample S every CLOCK_PER_BIT cycles. Shift the bits in LSB first until DATAWIDTH_BUS bits are captured.
  - Then go to PARITY if PARITY_MODE ≠ 0, otherwise to STOP.
- **PARITY.** Sample one bit, one bit period after the last data bit.
  - Even mode: error when XOR(data, parity bit) = 1.
  - Odd mode: error when XOR(data, parity bit) = 0.
- **STOP.** Sample STOP_BITS bits at one-bit spacing. Any low sample sets the pending frame error.
- **CLEANUP.** Lasts one cycle. In this cycle, load data_Out and both error flags from the pending values, and pulse newData_Out. Then return to IDLE.
- **Delivery on error.** A frame with a framing or parity error is still delivered, with its flags set.
- **Output hold.** data_Out and both flags hold their values until the next CLEANUP.
- **Break condition.** If the line is still low after CLEANUP, no new start is detected until S returns high, because a start requires a falling edge. A long break therefore produces exactly one frame with frameError = 1.
- **busy_Out.** High in START, DATA, PARITY, STOP and CLEANUP; low in IDLE.

## Timing
- **Reset values.** While RESET_InLow = 0, asynchronously:
  - state = IDLE;
  - newData, data, parityError, frameError and busy = 0;
  - synchroniser flops = 1.
- **Reset release.** No start is detected while the line is high after reset.
- **Reset mid-frame.** The partial frame is discarded and no strobe is produced.
- **Cycle reference.** Let cycle t be the first cycle with S = 0 after a start edge; the pin fell 2 clocks earlier.
- **Sample points:**
  - start bit at t+H;
  - data bit k (k = 0..W-1) at t+H+(k+1)·CPB;
  - parity bit at t+H+(W+1)·CPB;
  - stop bit j at t+H+(W+P+1+j)·CPB, where P = 1 if parity is enabled, else 0.
- **Latency.** newData_Out is high for exactly one cycle, the cycle after the final stop sample. Total latency from t is H+(W+P+STOP_BITS)·CPB+1.
- **Back-to-back frames.** A start edge arriving in the CLEANUP cycle or later is accepted. Consecutive frames with no idle gap are received without loss.
- **Glitch rejection.** A low pulse on S shorter than H cycles is rejected.

## Test plan
- **Basic frame.** CPB = 16, 8N1, byte 0xA5 → newData pulse at t+153; data = 0xA5; parityError = 0; frameError = 0; busy low at t+154.
- **Parity.** Even parity, byte 0x07 with parity bit 1 → data = 0x07, parityError = 0. Same byte with parity bit 0 → parityError = 1. Odd mode, same two frames → flags inverted.
- **Framing error.** Byte 0x3C with stop bit driven low, then line held low for 40 bit times → exactly one strobe, data = 0x3C, frameError = 1. After the line returns high, the next frame 0x55 gives frameError = 0.
- **False start.** 5-cycle low glitch at CPB = 16 → returns to IDLE, no strobe, outputs unchanged; a following 0x81 frame is received correctly.
- **Reset mid-frame.** Assert reset at data bit 4 of 0xFF → all outputs 0 immediately. After release, the next frame 0x12 is received correctly with no spurious strobe.
- **Wide back-to-back frames.** DATAWIDTH_BUS = 9, STOP_BITS = 2, odd parity, frames 0x1AB and 0x054 back-to-back → two strobes spaced (1+9+1+2)·CPB cycles apart, correct data, no errors.
